// File: rtl/tcdm_bank_resp_if.sv
// Request/response bundle between one TCDM crossbar slave port and its bank.
// Signal names keep the bank's _i/_o view so both sides read the same.
interface tcdm_bank_resp_if #(
   parameter int AddrMemWidth = 12,
   parameter int DataWidth    = 32,
   parameter int IdWidth      = 8
);
   localparam int BeWidth = DataWidth / 8;

   logic                    req_i;
   logic                    gnt_o;
   logic [AddrMemWidth-1:0] add_i;
   logic                    wen_i;
   logic [DataWidth-1:0]    wdata_i;
   logic [BeWidth-1:0]      be_i;
   logic                    ts_set_i;
   logic [IdWidth-1:0]      id_i;
   logic                    rvalid_o;
   logic [DataWidth-1:0]    rdata_o;
   logic [IdWidth-1:0]      r_id_o;

   modport master (
      output req_i, add_i, wen_i, wdata_i, be_i, ts_set_i, id_i,
      input  gnt_o, rvalid_o, rdata_o, r_id_o
   );

   modport slave (
      input  req_i, add_i, wen_i, wdata_i, be_i, ts_set_i, id_i,
      output gnt_o, rvalid_o, rdata_o, r_id_o
   );
endinterface

// File: rtl/tcdm_bank_resp.sv
// TCDM bank responder: single-port word storage with byte-enabled stores,
// test-and-set, and a fixed-latency {valid, id, data} response pipe.
module tcdm_bank_resp #(
   parameter int AddrMemWidth = 12,
   parameter int DataWidth    = 32,
   parameter int IdWidth      = 8,
   parameter int RespLatency  = 1
) (
   input logic                clk_i,
   input logic                rst_i,
   input logic                stall_i,
   tcdm_bank_resp_if.slave    bus
);
   localparam int BeWidth = DataWidth / 8;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] TS_WB = 1'b1;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
   } resp_t;

   logic [DataWidth-1:0]    mem [2**AddrMemWidth];
   logic [0:0]              state_q;
   logic                    busy_q;
   logic [AddrMemWidth-1:0] ts_addr_q;
   logic                    xfer;
   logic [RespLatency:1]    vld_pipe;
   resp_t                   resp_pipe [RespLatency:1];

   assign busy_q    = (state_q == TS_WB);
   assign bus.gnt_o = bus.req_i & ~stall_i & ~busy_q;
   assign xfer      = bus.req_i & bus.gnt_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ts_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE:    if (xfer && bus.wen_i && bus.ts_set_i) begin
                        state_q   <= TS_WB;
                        ts_addr_q <= bus.add_i;
                     end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Writeback is cancelled if reset lands on it, so the word keeps its old value.
   always_ff @(posedge clk_i) begin
      if (busy_q && !rst_i) begin
         mem[ts_addr_q] <= '1;
      end else if (xfer && !bus.wen_i) begin
         for (int b = 0; b < BeWidth; b++)
            if (bus.be_i[b]) mem[bus.add_i][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe <= '0;
         for (int s = 1; s <= RespLatency; s++) resp_pipe[s] <= '0;
      end else begin
         vld_pipe[1]       <= xfer;
         resp_pipe[1].id   <= xfer ? bus.id_i : '0;
         resp_pipe[1].data <= (xfer && bus.wen_i) ? mem[bus.add_i] : '0;
         for (int s = 2; s <= RespLatency; s++) begin
            vld_pipe[s]  <= vld_pipe[s-1];
            resp_pipe[s] <= resp_pipe[s-1];
         end
      end
   end

   assign bus.rvalid_o = vld_pipe[RespLatency];
   assign bus.r_id_o   = resp_pipe[RespLatency].id;
   assign bus.rdata_o  = resp_pipe[RespLatency].data;
endmodule

// File: tb/tb_tcdm_bank_resp.sv
// Directed bench for tcdm_bank_resp: latency-1 instance for functional cases,
// latency-3 instance for the stall/latency case.
module tb_tcdm_bank_resp;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic st1 = 1'b0;
   logic st3 = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   tcdm_bank_resp_if #(.AddrMemWidth(12), .DataWidth(32), .IdWidth(8)) b1 ();
   tcdm_bank_resp_if #(.AddrMemWidth(12), .DataWidth(32), .IdWidth(8)) b3 ();

   tcdm_bank_resp #(.AddrMemWidth(12), .DataWidth(32), .IdWidth(8), .RespLatency(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .stall_i(st1), .bus(b1.slave));
   tcdm_bank_resp #(.AddrMemWidth(12), .DataWidth(32), .IdWidth(8), .RespLatency(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .stall_i(st3), .bus(b3.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request on the latency-1 port, then let the grant settle.
   task automatic drv1(input logic req, input logic wen, input logic ts, input logic [11:0] add,
                       input logic [31:0] wd, input logic [3:0] be, input logic [7:0] id);
      b1.req_i = req; b1.wen_i = wen; b1.ts_set_i = ts; b1.add_i = add;
      b1.wdata_i = wd; b1.be_i = be; b1.id_i = id;
      #1;
   endtask

   task automatic drv3(input logic req, input logic wen, input logic [11:0] add,
                       input logic [31:0] wd, input logic [7:0] id);
      b3.req_i = req; b3.wen_i = wen; b3.ts_set_i = 1'b0; b3.add_i = add;
      b3.wdata_i = wd; b3.be_i = 4'hF; b3.id_i = id;
      #1;
   endtask

   task automatic rsp1(input string tag, input logic v, input logic [7:0] id, input logic [31:0] d);
      chk({tag, "_vld"}, b1.rvalid_o, v);
      if (v) begin
         chk({tag, "_id"}, b1.r_id_o, id);
         chk({tag, "_data"}, b1.rdata_o, d);
      end
   endtask

   initial begin
      drv1(0, 1, 0, 0, 0, 0, 0);
      drv3(0, 1, 0, 0, 0);
      tick(); tick();
      chk("rst_rvalid", b1.rvalid_o, 0);
      chk("rst_rdata", b1.rdata_o, 0);
      chk("rst_rid", b1.r_id_o, 0);
      chk("rst_rvalid3", b3.rvalid_o, 0);
      rst = 1'b0;
      tick();

      // store then load
      drv1(1, 0, 0, 12'd5, 32'hDEADBEEF, 4'hF, 8'd3);
      chk("st_gnt", b1.gnt_o, 1);
      tick();
      rsp1("st_rsp", 1, 8'd3, 32'h0);
      drv1(1, 1, 0, 12'd5, 0, 0, 8'd4);
      tick();
      rsp1("ld_rsp", 1, 8'd4, 32'hDEADBEEF);
      drv1(0, 1, 0, 0, 0, 0, 0);
      tick();
      chk("ld_single", b1.rvalid_o, 0);

      // byte enables
      drv1(1, 0, 0, 12'd7, 32'h11223344, 4'hF, 8'd5); tick();
      drv1(1, 0, 0, 12'd7, 32'hAABBCCDD, 4'b0101, 8'd6); tick();
      drv1(1, 1, 0, 12'd7, 0, 0, 8'd7); tick();
      rsp1("be_rsp", 1, 8'd7, 32'h11BB33DD);
      drv1(0, 1, 0, 0, 0, 0, 0);

      // test-and-set
      drv1(1, 0, 0, 12'd9, 32'h0, 4'hF, 8'd8); tick();
      drv1(1, 1, 1, 12'd9, 0, 0, 8'd9);
      chk("ts_gnt", b1.gnt_o, 1);
      tick();
      rsp1("ts_rsp", 1, 8'd9, 32'h0);
      drv1(1, 1, 0, 12'd9, 0, 0, 8'd10);
      chk("ts_wb_gnt", b1.gnt_o, 0);
      tick();
      chk("ts_post_gnt", b1.gnt_o, 1);
      chk("ts_wb_novld", b1.rvalid_o, 0);
      tick();
      rsp1("ts_ld_rsp", 1, 8'd10, 32'hFFFFFFFF);
      drv1(0, 1, 0, 0, 0, 0, 0);

      // stall with req held (latency 3)
      st1 = 1'b1;
      drv1(1, 1, 0, 12'd5, 0, 0, 8'd40);
      chk("st1_gnt", b1.gnt_o, 0);
      st1 = 1'b0;
      drv1(0, 1, 0, 0, 0, 0, 0);
      tick();
      st3 = 1'b1;
      drv3(1, 0, 12'd2, 32'hCAFEF00D, 8'd30);
      chk("stall_gnt0", b3.gnt_o, 0);
      tick();
      chk("stall_gnt1", b3.gnt_o, 0);
      chk("stall_novld", b3.rvalid_o, 0);
      tick();
      st3 = 1'b0; #1;
      chk("stall_free_gnt", b3.gnt_o, 1);
      tick();
      drv3(1, 1, 12'd2, 0, 8'd31);
      chk("lat_g1", b3.rvalid_o, 0);
      tick();
      drv3(0, 1, 0, 0, 0);
      chk("lat_g2", b3.rvalid_o, 0);
      tick();
      chk("lat_g3_vld", b3.rvalid_o, 1);
      chk("lat_g3_id", b3.r_id_o, 8'd30);
      tick();
      chk("lat_ld_vld", b3.rvalid_o, 1);
      chk("lat_ld_id", b3.r_id_o, 8'd31);
      chk("lat_ld_data", b3.rdata_o, 32'hCAFEF00D);
      tick();
      chk("lat_once", b3.rvalid_o, 0);

      // back-to-back ids
      drv1(1, 1, 0, 12'd5, 0, 0, 8'd1); tick();
      rsp1("b2b1", 1, 8'd1, 32'hDEADBEEF);
      drv1(1, 1, 0, 12'd5, 0, 0, 8'd2); tick();
      rsp1("b2b2", 1, 8'd2, 32'hDEADBEEF);
      drv1(1, 1, 0, 12'd5, 0, 0, 8'd3); tick();
      rsp1("b2b3", 1, 8'd3, 32'hDEADBEEF);
      drv1(0, 1, 0, 0, 0, 0, 0); tick();
      chk("b2b_end", b1.rvalid_o, 0);

      // reset during TS writeback
      drv1(1, 0, 0, 12'd11, 32'h12345678, 4'hF, 8'd20); tick();
      drv1(1, 1, 1, 12'd11, 0, 0, 8'd21); tick();
      rsp1("rts_rsp", 1, 8'd21, 32'h12345678);
      rst = 1'b1;
      drv1(0, 1, 0, 0, 0, 0, 0);
      tick();
      chk("rts_novld", b1.rvalid_o, 0);
      rst = 1'b0;
      drv1(1, 1, 0, 12'd11, 0, 0, 8'd22);
      chk("rts_gnt", b1.gnt_o, 1);
      tick();
      rsp1("rts_keep", 1, 8'd22, 32'h12345678);
      drv1(0, 1, 0, 0, 0, 0, 0);
      tick();
      chk("rts_end", b1.rvalid_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
